pill_dose_scheduler: RTL and testbench

//   Multi-channel pill-dose alarm engine; next generation of the pill-time reminder.
//   N_CH compartments each hold a programmable BCD dose time (hh:mm) and an enable bit.

---
 rtl/pill_sched_pkg.sv | 23 ++
 rtl/pill_ch_fsm.sv | 169 ++++++++++++++++
 rtl/pill_dose_scheduler.sv | 126 ++++++++++++
 tb/tb_pill_dose_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pill_sched_pkg.sv
// Package: pill_sched_pkg
// Shared types and constants for the pill-dose scheduler.
//   ch_state_t : per-channel alarm state (IDLE, RING, SNOOZE)
//   BCD_W      : width of a packed two-digit BCD field
//   SEC_ZERO   : BCD seconds value at which dose times are matched
//   cnt_width  : ring/snooze counter width for the given durations
package pill_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ch_state_t;

    localparam int BCD_W = 8;
    localparam logic [BCD_W-1:0] SEC_ZERO = 8'h00;

    // Enough bits to hold the longer of the two durations.
    function automatic int cnt_width(input int ring_s, input int snooze_s);
        return $clog2(((ring_s > snooze_s) ? ring_s : snooze_s) + 1);
    endfunction

endpackage

// File: rtl/pill_ch_fsm.sv
// Module: pill_ch_fsm
// One compartment: dose-time config registers, ring/snooze/missed FSM,
// seconds counter, snooze counter and sticky missed flag.
// Optional macro DOSE_COUNT_EN adds a saturating count of doses taken.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   sec_tick            a new second arrived (all counting is on this)
//   sec_is_zero         current RTC seconds are 00
//   hour_bcd, min_bcd   current RTC time
//   cfg_we              config write addressed to this channel
//   cfg_hour, cfg_min   dose time to store
//   cfg_en              channel enable to store
//   ack, snooze         1-cycle user pulses
//   miss_clr            clear the missed flag
//   is_ring, is_snooze  current state decode
//   missed              sticky missed-dose flag
//   dose_cnt            (DOSE_COUNT_EN) acks taken while active, saturating
module pill_ch_fsm
    import pill_sched_pkg::*;
#(
    parameter int RING_S     = 30,
    parameter int SNOOZE_S   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sec_tick,
    input  logic             sec_is_zero,
    input  logic [BCD_W-1:0] hour_bcd,
    input  logic [BCD_W-1:0] min_bcd,
    input  logic             cfg_we,
    input  logic [BCD_W-1:0] cfg_hour,
    input  logic [BCD_W-1:0] cfg_min,
    input  logic             cfg_en,
    input  logic             ack,
    input  logic             snooze,
    input  logic             miss_clr,
    output logic             is_ring,
    output logic             is_snooze,
    output logic             missed
`ifdef DOSE_COUNT_EN
    ,
    output logic [7:0]       dose_cnt
`endif
);

    localparam int CNT_W = cnt_width(RING_S, SNOOZE_S);
    localparam int SNZ_W = $clog2(MAX_SNOOZE + 2);
    localparam logic [CNT_W-1:0] RING_LD = CNT_W'(RING_S);
    localparam logic [CNT_W-1:0] SNZ_LD  = CNT_W'(SNOOZE_S);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SNZ_W-1:0] SNZ_MAX = SNZ_W'(MAX_SNOOZE);

    ch_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SNZ_W-1:0] snz_reg, snz_next, snz_inc;
    logic [BCD_W-1:0] cfg_hour_reg, cfg_min_reg;
    logic             cfg_en_reg;
    logic             missed_reg;
    logic             miss_set;
    logic             match;

    assign match = sec_tick && sec_is_zero && cfg_en_reg &&
                   (hour_bcd == cfg_hour_reg) && (min_bcd == cfg_min_reg);

    // Saturate so a snooze pressed after the last allowed cycle cannot wrap.
    assign snz_inc = (snz_reg == '1) ? snz_reg : snz_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        snz_next   = snz_reg;
        miss_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (match) begin
                    state_next = RING;
                    cnt_next   = RING_LD;
                    snz_next   = '0;
                end
            end
            RING: begin
                if (ack) begin
                    state_next = IDLE;
                end else if (snooze) begin
                    state_next = SNOOZE;
                    cnt_next   = SNZ_LD;
                    snz_next   = snz_inc;
                end else if (sec_tick) begin
                    // Counter reaching zero on this tick ends the ring.
                    if (cnt_reg <= CNT_ONE) begin
                        if (snz_reg < SNZ_MAX) begin
                            state_next = SNOOZE;
                            cnt_next   = SNZ_LD;
                            snz_next   = snz_inc;
                        end else begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            miss_set   = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (ack) begin
                    state_next = IDLE;
                end else if (sec_tick) begin
                    if (cnt_reg <= CNT_ONE) begin
                        state_next = RING;
                        cnt_next   = RING_LD;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Disabling a channel silences it at once; a new time alone does not.
        if (cfg_we && !cfg_en) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            snz_reg      <= '0;
            cfg_hour_reg <= '0;
            cfg_min_reg  <= '0;
            cfg_en_reg   <= 1'b0;
            missed_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            snz_reg   <= snz_next;
            if (cfg_we) begin
                cfg_hour_reg <= cfg_hour;
                cfg_min_reg  <= cfg_min;
                cfg_en_reg   <= cfg_en;
            end
            // A new miss beats a simultaneous clear.
            if (miss_set) begin
                missed_reg <= 1'b1;
            end else if (miss_clr) begin
                missed_reg <= 1'b0;
            end
        end
    end

`ifdef DOSE_COUNT_EN
    logic [7:0] dose_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dose_cnt_reg <= '0;
        end else if (ack && (state_reg != IDLE) && (dose_cnt_reg != 8'hFF)) begin
            dose_cnt_reg <= dose_cnt_reg + 8'd1;
        end
    end
    assign dose_cnt = dose_cnt_reg;
`endif

    assign is_ring   = (state_reg == RING);
    assign is_snooze = (state_reg == SNOOZE);
    assign missed    = missed_reg;

endmodule

// File: rtl/pill_dose_scheduler.sv
// Module: pill_dose_scheduler
// Multi-channel pill-dose alarm engine. Detects new RTC seconds, decodes
// config writes, runs one pill_ch_fsm per compartment and drives the
// registered LED / buzzer / activity outputs.
// Optional macro DOSE_COUNT_EN adds output dose_cnt (8 bits per channel).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   time_vld                      fresh RTC read on hour/min/sec_bcd
//   hour_bcd, min_bcd, sec_bcd    BCD time
//   cfg_we, cfg_ch                config write strobe and target channel
//   cfg_hour, cfg_min, cfg_en     dose time and enable to write
//   ack                           per-channel dose-taken pulse
//   snooze                        snoozes every ringing channel
//   miss_clr                      clears all missed flags
//   ch_led_n                      active-low compartment LEDs
//   buzzer_n                      active-low shared buzzer
//   missed                        sticky missed-dose flags
//   any_active                    some channel ringing or snoozed
module pill_dose_scheduler
    import pill_sched_pkg::*;
#(
    parameter int N_CH       = 5,
    parameter int RING_S     = 30,
    parameter int SNOOZE_S   = 60,
    parameter int MAX_SNOOZE = 3,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             time_vld,
    input  logic [7:0]       hour_bcd,
    input  logic [7:0]       min_bcd,
    input  logic [7:0]       sec_bcd,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [7:0]       cfg_hour,
    input  logic [7:0]       cfg_min,
    input  logic             cfg_en,
    input  logic [N_CH-1:0]  ack,
    input  logic             snooze,
    input  logic             miss_clr,
    output logic [N_CH-1:0]  ch_led_n,
    output logic             buzzer_n,
    output logic [N_CH-1:0]  missed,
    output logic             any_active
`ifdef DOSE_COUNT_EN
    ,
    output logic [N_CH*8-1:0] dose_cnt
`endif
);

    logic [7:0]      prev_sec_reg;
    logic            phase_reg;
    logic            sec_tick;
    logic            sec_is_zero;
    logic [N_CH-1:0] ch_we;
    logic [N_CH-1:0] ring_vec;
    logic [N_CH-1:0] snz_vec;
    logic [N_CH-1:0] led_n_reg;
    logic            buzzer_n_reg;
    logic            active_reg;

    // The RTC reader may repeat a read within one second; only a changed
    // seconds value counts as a tick.
    assign sec_tick    = time_vld && (sec_bcd != prev_sec_reg);
    assign sec_is_zero = (sec_bcd == SEC_ZERO);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            // Out-of-range cfg_ch equals no gi, so it is dropped here.
            assign ch_we[gi] = cfg_we && (cfg_ch == CW'(gi));

            pill_ch_fsm #(
                .RING_S     (RING_S),
                .SNOOZE_S   (SNOOZE_S),
                .MAX_SNOOZE (MAX_SNOOZE)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .sec_tick    (sec_tick),
                .sec_is_zero (sec_is_zero),
                .hour_bcd    (hour_bcd),
                .min_bcd     (min_bcd),
                .cfg_we      (ch_we[gi]),
                .cfg_hour    (cfg_hour),
                .cfg_min     (cfg_min),
                .cfg_en      (cfg_en),
                .ack         (ack[gi]),
                .snooze      (snooze),
                .miss_clr    (miss_clr),
                .is_ring     (ring_vec[gi]),
                .is_snooze   (snz_vec[gi]),
                .missed      (missed[gi])
`ifdef DOSE_COUNT_EN
                ,
                .dose_cnt    (dose_cnt[gi*8 +: 8])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sec_reg <= 8'hFF;
            phase_reg    <= 1'b0;
            led_n_reg    <= '1;
            buzzer_n_reg <= 1'b1;
            active_reg   <= 1'b0;
        end else begin
            if (time_vld) begin
                prev_sec_reg <= sec_bcd;
                // Even seconds are the "on" half of the blink.
                phase_reg    <= ~sec_bcd[0];
            end
            // Ringing LEDs blink, snoozed LEDs stay lit.
            led_n_reg    <= ~((ring_vec & {N_CH{phase_reg}}) | snz_vec);
            buzzer_n_reg <= ~((|ring_vec) & phase_reg);
            active_reg   <= |(ring_vec | snz_vec);
        end
    end

    assign ch_led_n   = led_n_reg;
    assign buzzer_n   = buzzer_n_reg;
    assign any_active = active_reg;

endmodule

// File: tb/tb_pill_dose_scheduler.sv
// Testbench: tb_pill_dose_scheduler
// Directed stimulus; each expected output snapshot is pushed into a
// scoreboard queue and a separate negedge monitor pops and compares it.
module tb_pill_dose_scheduler;

    localparam int N_CH = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       time_vld;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_hour, cfg_min;
    logic       cfg_en;
    logic [4:0] ack;
    logic       snooze;
    logic       miss_clr;
    logic [4:0] ch_led_n;
    logic       buzzer_n;
    logic [4:0] missed;
    logic       any_active;
`ifdef DOSE_COUNT_EN
    logic [N_CH*8-1:0] dose_cnt;
`endif

    always #5 clk = ~clk;

    pill_dose_scheduler #(
        .N_CH       (N_CH),
        .RING_S     (30),
        .SNOOZE_S   (60),
        .MAX_SNOOZE (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_vld   (time_vld),
        .hour_bcd   (hour_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_hour   (cfg_hour),
        .cfg_min    (cfg_min),
        .cfg_en     (cfg_en),
        .ack        (ack),
        .snooze     (snooze),
        .miss_clr   (miss_clr),
        .ch_led_n   (ch_led_n),
        .buzzer_n   (buzzer_n),
        .missed     (missed),
        .any_active (any_active)
`ifdef DOSE_COUNT_EN
        ,
        .dose_cnt   (dose_cnt)
`endif
    );

    typedef struct {
        logic [4:0] led_n;
        logic       buz_n;
        logic [4:0] mis;
        logic       act;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  chk_req  = 1'b0;

    // Monitor: one scoreboard entry per requested sample, away from posedge.
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t  e;
            string nm;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: sample requested with no expectation");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (ch_led_n !== e.led_n || buzzer_n !== e.buz_n ||
                    missed !== e.mis || any_active !== e.act) begin
                    failures++;
                    $display("FAIL %s: got led_n=%b buz_n=%b missed=%b act=%b, want led_n=%b buz_n=%b missed=%b act=%b",
                             nm, ch_led_n, buzzer_n, missed, any_active,
                             e.led_n, e.buz_n, e.mis, e.act);
                end else begin
                    $display("ok   %s: led_n=%b buz_n=%b missed=%b act=%b",
                             nm, ch_led_n, buzzer_n, missed, any_active);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [4:0] led,
                              input logic buz, input logic [4:0] mis, input logic act);
        exp_t e;
        e.led_n = led;
        e.buz_n = buz;
        e.mis   = mis;
        e.act   = act;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        step();
        chk_req = 1'b0;
    endtask

    task automatic tick(input int h, input int m, input int s);
        hour_bcd = bcd(h);
        min_bcd  = bcd(m);
        sec_bcd  = bcd(s);
        time_vld = 1'b1;
        step();
        time_vld = 1'b0;
    endtask

    // A seconds value of 59 never matches, but guarantees the following
    // hh:mm:00 read is seen as a new second.
    task automatic fire(input int h, input int m);
        tick(0, 0, 59);
        tick(h, m, 0);
    endtask

    task automatic cfg_write(input int ch, input int h, input int m, input logic en);
        cfg_ch   = 3'(ch);
        cfg_hour = bcd(h);
        cfg_min  = bcd(m);
        cfg_en   = en;
        cfg_we   = 1'b1;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] a, input logic s, input logic c);
        ack      = a;
        snooze   = s;
        miss_clr = c;
        step();
        ack      = '0;
        snooze   = 1'b0;
        miss_clr = 1'b0;
    endtask

    // Channel ch rings unattended from h:00:00: rings at 0,90,180,270 s,
    // snoozes at 30,120,210 s, declared missed at 300 s.
    task automatic ring_to_miss(input int ch, input int h, input logic clr_at_end,
                                input string tag);
        logic [4:0] on;
        logic [4:0] mask;
        mask = 5'(1 << ch);
        on   = ~mask;
        tick(0, 0, 59);
        for (int k = 0; k <= 300; k++) begin
            if (k == 300 && clr_at_end) miss_clr = 1'b1;
            tick(h, k / 60, k % 60);
            miss_clr = 1'b0;
            case (k)
                0:   begin step(); expect_out({tag, "_ring_start"},   on,    1'b0, 5'b0, 1'b1); end
                29:  begin step(); expect_out({tag, "_ring_s29_off"}, 5'h1F, 1'b1, 5'b0, 1'b1); end
                30:  begin step(); expect_out({tag, "_snooze1"},      on,    1'b1, 5'b0, 1'b1); end
                89:  begin step(); expect_out({tag, "_snooze1_end"},  on,    1'b1, 5'b0, 1'b1); end
                90:  begin step(); expect_out({tag, "_ring2"},        on,    1'b0, 5'b0, 1'b1); end
                270: begin step(); expect_out({tag, "_ring4"},        on,    1'b0, 5'b0, 1'b1); end
                299: begin step(); expect_out({tag, "_ring4_last"},   5'h1F, 1'b1, 5'b0, 1'b1); end
                300: begin step(); expect_out({tag, "_missed"},       5'h1F, 1'b1, mask, 1'b0); end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        time_vld = 1'b0;
        hour_bcd = '0;
        min_bcd  = '0;
        sec_bcd  = '0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_hour = '0;
        cfg_min  = '0;
        cfg_en   = 1'b0;
        ack      = '0;
        snooze   = 1'b0;
        miss_clr = 1'b0;
        step();
        step();
        expect_out("reset_values", 5'h1F, 1'b1, 5'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: basic ring, blink with seconds parity, ack
        cfg_write(2, 8, 30, 1'b1);
        tick(8, 30, 0);
        step(); expect_out("t1_ring_even",  5'b11011, 1'b0, 5'b0, 1'b1);
        tick(8, 30, 1);
        step(); expect_out("t1_ring_odd",   5'b11111, 1'b1, 5'b0, 1'b1);
        tick(8, 30, 2);
        step(); expect_out("t1_ring_even2", 5'b11011, 1'b0, 5'b0, 1'b1);
        pulse(5'b00100, 1'b0, 1'b0);
        step(); expect_out("t1_ack_idle",   5'b11111, 1'b1, 5'b0, 1'b0);

        // 2: unattended ring to missed, then clear
        cfg_write(2, 9, 0, 1'b1);
        ring_to_miss(2, 9, 1'b0, "t2");
        pulse(5'b0, 1'b0, 1'b1);
        step(); expect_out("t2_miss_clr", 5'b11111, 1'b1, 5'b0, 1'b0);

        // 3: two channels ring together; ack one
        cfg_write(0, 12, 0, 1'b1);
        cfg_write(4, 12, 0, 1'b1);
        fire(12, 0);
        step(); expect_out("t3_both_ring", 5'b01110, 1'b0, 5'b0, 1'b1);
        pulse(5'b00001, 1'b0, 1'b0);
        step(); expect_out("t3_ch4_left",  5'b01111, 1'b0, 5'b0, 1'b1);
        pulse(5'b10000, 1'b0, 1'b0);
        step(); expect_out("t3_all_idle",  5'b11111, 1'b1, 5'b0, 1'b0);

        // 4: ack beats snooze
        cfg_write(1, 13, 0, 1'b1);
        fire(13, 0);
        step(); expect_out("t4_ring",         5'b11101, 1'b0, 5'b0, 1'b1);
        pulse(5'b00010, 1'b1, 1'b0);
        step(); expect_out("t4_ack_over_snz", 5'b11111, 1'b1, 5'b0, 1'b0);

        // 5: disable while ringing; out-of-range channel ignored
        cfg_write(3, 14, 0, 1'b1);
        fire(14, 0);
        step(); expect_out("t5_ring",        5'b10111, 1'b0, 5'b0, 1'b1);
        cfg_write(7, 14, 0, 1'b0);
        step(); expect_out("t5_bad_ch_noop", 5'b10111, 1'b0, 5'b0, 1'b1);
        cfg_write(3, 14, 0, 1'b0);
        step(); expect_out("t5_disabled",    5'b11111, 1'b1, 5'b0, 1'b0);

        // miss_clr in the same cycle as a new miss: the set wins
        cfg_write(3, 15, 0, 1'b1);
        ring_to_miss(3, 15, 1'b1, "tm");

        // 6: repeated identical read gives one match; reset mid-ring
        cfg_write(0, 16, 0, 1'b1);
        fire(16, 0);
        step(); expect_out("t6_ring",         5'b11110, 1'b0, 5'b01000, 1'b1);
        pulse(5'b00001, 1'b0, 1'b0);
        tick(16, 0, 0);
        step(); expect_out("t6_no_rematch",   5'b11111, 1'b1, 5'b01000, 1'b0);
        cfg_write(0, 17, 0, 1'b1);
        fire(17, 0);
        step(); expect_out("t6_ring_again",   5'b11110, 1'b0, 5'b01000, 1'b1);
        rst_n = 1'b0;
        #1;
        expect_out("t6_reset_mid_ring",       5'b11111, 1'b1, 5'b0, 1'b0);
        rst_n = 1'b1;
        step();
        tick(17, 0, 0);
        step(); expect_out("t6_cfg_lost",     5'b11111, 1'b1, 5'b0, 1'b0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
